seq_detector: RTL

Streaming word-sequence detector that sits downstream of the equality comparator stage. It holds a programmable key of DEPTH words and compares each accepted input word against the expected key word using LENGTH-bit equality. It emits a registered one-cycle `match` pulse when the full key sequence arrives on consecutive accepted words.

---
 rtl/seq_detector.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_detector.sv
// Streaming word-sequence detector: matches DEPTH consecutive accepted words against a loaded key.
// Optional saturating match counter compiled in with SEQ_DETECTOR_COUNT_EN.
module seq_detector #(
  parameter int LENGTH = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_load,
  input  logic [LENGTH*DEPTH-1:0] key_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LENGTH-1:0]       in_data,
  output logic                    match,
  output logic                    armed
`ifdef SEQ_DETECTOR_COUNT_EN
  ,
  output logic [CNT_W-1:0]        match_count
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // Parameter combinations outside the supported range leave this marker block in the hierarchy.
  if ((DEPTH < 2) || (CNT_W < 1)) begin : g_bad_params
  end

  function automatic logic [LENGTH-1:0] key_word(
    input logic [LENGTH*DEPTH-1:0] key,
    input logic [IDX_W-1:0]        idx
  );
    key_word = key[int'(idx)*LENGTH +: LENGTH];
  endfunction

  state_e                  state_q, state_d;
  logic [LENGTH*DEPTH-1:0] key_q, key_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    match_q, match_d;
  logic                    accept_s;
  logic                    eq_s;
  logic                    eq_first_s;
  logic                    last_s;

  assign in_ready   = (state_q == ARMED) && !key_load;
  assign accept_s   = in_valid && in_ready;
  assign eq_s       = (in_data == key_word(key_q, idx_q));
  assign eq_first_s = (in_data == key_word(key_q, IDX_W'(0)));
  assign last_s     = (idx_q == IDX_LAST);
  assign armed      = (state_q == ARMED);
  assign match      = match_q;

  // Next-state logic; a mismatch restarts at word 1 only when it equals key word 0 (no KMP recovery).
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    match_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          state_d = ARMED;
          key_d   = key_in;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (key_load) begin
          key_d = key_in;
          idx_d = '0;
        end else if (accept_s) begin
          if (eq_s) begin
            if (last_s) begin
              match_d = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (eq_first_s) begin
            idx_d = IDX_W'(1);
          end else begin
            idx_d = '0;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, key, index and match pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      match_q <= match_d;
    end
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter advances alongside the match pulse so both become visible in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Match counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`endif

endmodule
